// File: rtl/mmu_tlb.sv
// Fully associative MIPS-style joint TLB with 4 KB even/odd page pairs.
//
// Lookup side: combinational match on lookup_* inputs, results registered, so
// every request gets its answer (lookup_ack plus paddr/flags) on the next cycle.
// Op side: CP0 TLBR/TLBWI/TLBWR/TLBP run through a three-state sequencer
// (IDLE -> EXEC -> DONE). The entry array and result registers update at the
// EXEC clock edge; op_done pulses in DONE.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   lookup_req/vaddr/store/asid     translation request
//   lookup_ack/paddr/uncached       registered translation response
//   lookup_miss/invalid/modified    registered exception flags (at most one set)
//   op_valid/op_code/op_ready       CP0 TLB instruction handshake
//   op_done                         one-cycle completion pulse
//   entryhi_in/entrylo0_in/entrylo1_in/index_in  CP0 operands, latched at accept
//   wired_in                        Wired register, lower bound for Random
//   entryhi_out/entrylo0_out/entrylo1_out        TLBR results
//   index_out                       TLBP result (bit 31 set on probe miss)
//   random_out                      current Random register
module mmu_tlb #(
  parameter int unsigned NUM_ENTRIES = 16,
  localparam int unsigned IW = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lookup_req,
  input  logic [31:0]   lookup_vaddr,
  input  logic          lookup_store,
  input  logic [7:0]    lookup_asid,
  output logic          lookup_ack,
  output logic [31:0]   lookup_paddr,
  output logic          lookup_uncached,
  output logic          lookup_miss,
  output logic          lookup_invalid,
  output logic          lookup_modified,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  output logic          op_done,
  input  logic [31:0]   entryhi_in,
  input  logic [31:0]   entrylo0_in,
  input  logic [31:0]   entrylo1_in,
  input  logic [IW-1:0] index_in,
  input  logic [IW-1:0] wired_in,
  output logic [31:0]   entryhi_out,
  output logic [31:0]   entrylo0_out,
  output logic [31:0]   entrylo1_out,
  output logic [31:0]   index_out,
  output logic [IW-1:0] random_out
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} op_state_e;

  localparam logic [1:0] OpTlbr  = 2'b00;
  localparam logic [1:0] OpTlbwi = 2'b01;
  localparam logic [1:0] OpTlbwr = 2'b10;
  localparam logic [1:0] OpTlbp  = 2'b11;

  localparam logic [IW-1:0] LastIdx = IW'(NUM_ENTRIES - 1);

  // Entry array, one field per array so each half can be selected cheaply.
  logic [18:0]            vpn2_q [NUM_ENTRIES];
  logic [7:0]             asid_q [NUM_ENTRIES];
  logic [19:0]            pfn0_q [NUM_ENTRIES];
  logic [19:0]            pfn1_q [NUM_ENTRIES];
  logic [2:0]             c0_q   [NUM_ENTRIES];
  logic [2:0]             c1_q   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] g_q, d0_q, v0_q, d1_q, v1_q;

  // Operands captured at accept.
  logic [1:0]    op_code_q;
  logic [18:0]   op_vpn2_q;
  logic [7:0]    op_asid_q;
  logic [25:0]   op_lo0_q;
  logic [25:0]   op_lo1_q;
  logic [IW-1:0] op_index_q;
  logic [IW-1:0] op_rand_q;

  op_state_e     state_q, state_d;
  logic [IW-1:0] random_q, random_d;
  logic          op_accept;

  // Registered lookup response.
  logic        ack_q, unc_q, miss_q, inv_q, mod_q;
  logic [31:0] paddr_q;
  logic        unc_d, miss_d, inv_d, mod_d;
  logic [31:0] paddr_d;

  // Registered op results.
  logic [31:0] ehi_q, elo0_q, elo1_q, index_q;

  // Bits of the CP0 operands the TLB has no field for.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{entryhi_in[12:8], entrylo0_in[31:26], entrylo1_in[31:26]};

  function automatic logic [IW-1:0] lowest_set(input logic [NUM_ENTRIES-1:0] vec);
    lowest_set = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = IW'(i);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Match vectors for the lookup port and for TLBP (latched EntryHi)
  // ---------------------------------------------------------------------------
  logic [NUM_ENTRIES-1:0] lk_match, pr_match;

  always_comb begin
    lk_match = '0;
    pr_match = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      lk_match[i] = (vpn2_q[i] == lookup_vaddr[31:13]) &&
                    (g_q[i] || (asid_q[i] == lookup_asid));
      pr_match[i] = (vpn2_q[i] == op_vpn2_q) && (g_q[i] || (asid_q[i] == op_asid_q));
    end
  end

  logic [IW-1:0] lk_idx, pr_idx;
  logic [19:0]   lk_pfn;
  logic [2:0]    lk_c;
  logic          lk_d, lk_v;

  assign lk_idx = lowest_set(lk_match);
  assign pr_idx = lowest_set(pr_match);

  // vaddr[12] picks the odd (EntryLo1) page of the pair.
  assign lk_pfn = lookup_vaddr[12] ? pfn1_q[lk_idx] : pfn0_q[lk_idx];
  assign lk_c   = lookup_vaddr[12] ? c1_q[lk_idx]   : c0_q[lk_idx];
  assign lk_d   = lookup_vaddr[12] ? d1_q[lk_idx]   : d0_q[lk_idx];
  assign lk_v   = lookup_vaddr[12] ? v1_q[lk_idx]   : v0_q[lk_idx];

  always_comb begin
    paddr_d = '0;
    unc_d   = 1'b0;
    miss_d  = 1'b0;
    inv_d   = 1'b0;
    mod_d   = 1'b0;
    if (lookup_req) begin
      if (lk_match == '0) begin
        miss_d = 1'b1;
      end else if (!lk_v) begin
        inv_d = 1'b1;
      end else if (lookup_store && !lk_d) begin
        mod_d = 1'b1;
      end else begin
        paddr_d = {lk_pfn, lookup_vaddr[11:0]};
        unc_d   = (lk_c == 3'b010);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Random: counts down, wrapping to the top once it reaches (or is below) Wired
  // ---------------------------------------------------------------------------
  always_comb begin
    if (wired_in >= random_q) begin
      random_d = LastIdx;
    end else begin
      random_d = random_q - IW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Op sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_ready = 1'b0;
    op_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        op_ready = !rst;
        if (op_valid && !rst) state_d = StExec;
      end
      StExec: state_d = StDone;
      StDone: begin
        // A reset landing in DONE kills the pulse.
        op_done = !rst;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign op_accept = op_valid && op_ready;

  logic [IW-1:0] wr_idx;
  assign wr_idx = (op_code_q == OpTlbwi) ? op_index_q : op_rand_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      random_q   <= LastIdx;
      op_code_q  <= '0;
      op_vpn2_q  <= '0;
      op_asid_q  <= '0;
      op_lo0_q   <= '0;
      op_lo1_q   <= '0;
      op_index_q <= '0;
      op_rand_q  <= '0;
      ack_q      <= 1'b0;
      paddr_q    <= '0;
      unc_q      <= 1'b0;
      miss_q     <= 1'b0;
      inv_q      <= 1'b0;
      mod_q      <= 1'b0;
      ehi_q      <= '0;
      elo0_q     <= '0;
      elo1_q     <= '0;
      index_q    <= '0;
      g_q        <= '0;
      d0_q       <= '0;
      v0_q       <= '0;
      d1_q       <= '0;
      v1_q       <= '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        pfn0_q[i] <= '0;
        pfn1_q[i] <= '0;
        c0_q[i]   <= '0;
        c1_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      random_q <= random_d;

      ack_q   <= lookup_req;
      paddr_q <= paddr_d;
      unc_q   <= unc_d;
      miss_q  <= miss_d;
      inv_q   <= inv_d;
      mod_q   <= mod_d;

      if (op_accept) begin
        op_code_q  <= op_code;
        op_vpn2_q  <= entryhi_in[31:13];
        op_asid_q  <= entryhi_in[7:0];
        op_lo0_q   <= entrylo0_in[25:0];
        op_lo1_q   <= entrylo1_in[25:0];
        op_index_q <= index_in;
        // TLBWR targets the Random value seen in the accept cycle.
        op_rand_q  <= random_q;
      end

      if (state_q == StExec) begin
        unique case (op_code_q)
          OpTlbr: begin
            ehi_q  <= {vpn2_q[op_index_q], 5'b0, asid_q[op_index_q]};
            elo0_q <= {6'b0, pfn0_q[op_index_q], c0_q[op_index_q], d0_q[op_index_q],
                       v0_q[op_index_q], g_q[op_index_q]};
            elo1_q <= {6'b0, pfn1_q[op_index_q], c1_q[op_index_q], d1_q[op_index_q],
                       v1_q[op_index_q], g_q[op_index_q]};
          end
          OpTlbwi, OpTlbwr: begin
            vpn2_q[wr_idx] <= op_vpn2_q;
            asid_q[wr_idx] <= op_asid_q;
            g_q[wr_idx]    <= op_lo0_q[0] & op_lo1_q[0];
            pfn0_q[wr_idx] <= op_lo0_q[25:6];
            c0_q[wr_idx]   <= op_lo0_q[5:3];
            d0_q[wr_idx]   <= op_lo0_q[2];
            v0_q[wr_idx]   <= op_lo0_q[1];
            pfn1_q[wr_idx] <= op_lo1_q[25:6];
            c1_q[wr_idx]   <= op_lo1_q[5:3];
            d1_q[wr_idx]   <= op_lo1_q[2];
            v1_q[wr_idx]   <= op_lo1_q[1];
          end
          OpTlbp: begin
            if (pr_match != '0) begin
              index_q <= {{(32 - IW){1'b0}}, pr_idx};
            end else begin
              index_q <= 32'h8000_0000;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign lookup_ack      = ack_q;
  assign lookup_paddr    = paddr_q;
  assign lookup_uncached = unc_q;
  assign lookup_miss     = miss_q;
  assign lookup_invalid  = inv_q;
  assign lookup_modified = mod_q;
  assign entryhi_out     = ehi_q;
  assign entrylo0_out    = elo0_q;
  assign entrylo1_out    = elo1_q;
  assign index_out       = index_q;
  assign random_out      = random_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb (NUM_ENTRIES = 16). A behavioural model of the
// TLB contents, Random register and op timing is checked against the DUT on
// every falling edge; directed literal checks pin the model on known cases.
module tb_mmu_tlb;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk;
  logic          rst;
  logic          lookup_req;
  logic [31:0]   lookup_vaddr;
  logic          lookup_store;
  logic [7:0]    lookup_asid;
  logic          lookup_ack;
  logic [31:0]   lookup_paddr;
  logic          lookup_uncached;
  logic          lookup_miss;
  logic          lookup_invalid;
  logic          lookup_modified;
  logic          op_valid;
  logic [1:0]    op_code;
  logic          op_ready;
  logic          op_done;
  logic [31:0]   entryhi_in;
  logic [31:0]   entrylo0_in;
  logic [31:0]   entrylo1_in;
  logic [IW-1:0] index_in;
  logic [IW-1:0] wired_in;
  logic [31:0]   entryhi_out;
  logic [31:0]   entrylo0_out;
  logic [31:0]   entrylo1_out;
  logic [31:0]   index_out;
  logic [IW-1:0] random_out;

  mmu_tlb #(.NUM_ENTRIES(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_req     (lookup_req),
    .lookup_vaddr   (lookup_vaddr),
    .lookup_store   (lookup_store),
    .lookup_asid    (lookup_asid),
    .lookup_ack     (lookup_ack),
    .lookup_paddr   (lookup_paddr),
    .lookup_uncached(lookup_uncached),
    .lookup_miss    (lookup_miss),
    .lookup_invalid (lookup_invalid),
    .lookup_modified(lookup_modified),
    .op_valid       (op_valid),
    .op_code        (op_code),
    .op_ready       (op_ready),
    .op_done        (op_done),
    .entryhi_in     (entryhi_in),
    .entrylo0_in    (entrylo0_in),
    .entrylo1_in    (entrylo1_in),
    .index_in       (index_in),
    .wired_in       (wired_in),
    .entryhi_out    (entryhi_out),
    .entrylo0_out   (entrylo0_out),
    .entrylo1_out   (entrylo1_out),
    .index_out      (index_out),
    .random_out     (random_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Model: entries kept in TLBR read-back format
  // ---------------------------------------------------------------------------
  logic [31:0] m_hi [N];
  logic [31:0] m_lo0 [N];
  logic [31:0] m_lo1 [N];
  int          m_rand;
  int          since_accept;  // -1 when no op is in flight
  logic [1:0]  l_code;
  logic [31:0] l_hi, l_lo0, l_lo1;
  int          l_idx, l_rand;
  logic        e_ack, e_unc, e_miss, e_inv, e_mod;
  logic [31:0] e_paddr, e_ehi, e_elo0, e_elo1, e_index;
  bit          primed = 0;

  function automatic int find_entry(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int i = 0; i < N; i++) begin
      if (m_hi[i][31:13] == vpn2 && (m_lo0[i][0] || m_hi[i][7:0] == asid)) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int          hit;
    int          w;
    logic [31:0] half;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0;
      end
      m_rand = N - 1;
      since_accept = -1;
      {e_ack, e_unc, e_miss, e_inv, e_mod} = '0;
      e_paddr = '0; e_ehi = '0; e_elo0 = '0; e_elo1 = '0; e_index = '0;
      return;
    end
    // Lookup is evaluated against the contents before any write at this edge.
    e_ack = lookup_req;
    {e_unc, e_miss, e_inv, e_mod} = '0;
    e_paddr = '0;
    if (lookup_req) begin
      hit = find_entry(lookup_vaddr[31:13], lookup_asid);
      if (hit < 0) e_miss = 1'b1;
      else begin
        half = lookup_vaddr[12] ? m_lo1[hit] : m_lo0[hit];
        if (!half[1]) e_inv = 1'b1;
        else if (lookup_store && !half[2]) e_mod = 1'b1;
        else begin
          e_paddr = {half[25:6], lookup_vaddr[11:0]};
          e_unc = (half[5:3] == 3'd2);
        end
      end
    end
    if (since_accept < 0) begin
      if (op_valid) begin
        l_code = op_code; l_hi = entryhi_in; l_lo0 = entrylo0_in; l_lo1 = entrylo1_in;
        l_idx = int'(index_in); l_rand = m_rand;
        since_accept = 0;
      end
    end else if (since_accept == 0) begin
      case (l_code)
        2'b00: begin
          e_ehi = m_hi[l_idx]; e_elo0 = m_lo0[l_idx]; e_elo1 = m_lo1[l_idx];
        end
        2'b11: begin
          hit = find_entry(l_hi[31:13], l_hi[7:0]);
          e_index = (hit < 0) ? 32'h8000_0000 : hit;
        end
        default: begin
          w = (l_code == 2'b01) ? l_idx : l_rand;
          m_hi[w]  = {l_hi[31:13], 5'b0, l_hi[7:0]};
          m_lo0[w] = {6'b0, l_lo0[25:1], l_lo0[0] & l_lo1[0]};
          m_lo1[w] = {6'b0, l_lo1[25:1], l_lo0[0] & l_lo1[0]};
        end
      endcase
      since_accept = 1;
    end else begin
      since_accept = -1;
    end
    m_rand = (int'(wired_in) >= m_rand) ? N - 1 : m_rand - 1;
  endtask

  // Compare process: outputs launched by the last rising edge vs the model.
  always @(negedge clk) begin
    if (primed) begin
      chk("lookup_ack", lookup_ack, e_ack);
      chk("lookup_paddr", lookup_paddr, e_paddr);
      chk("lookup_uncached", lookup_uncached, e_unc);
      chk("lookup_miss", lookup_miss, e_miss);
      chk("lookup_invalid", lookup_invalid, e_inv);
      chk("lookup_modified", lookup_modified, e_mod);
      chk("random_out", random_out, m_rand);
      chk("op_ready", op_ready, (since_accept < 0) && !rst);
      chk("op_done", op_done, (since_accept == 1) && !rst);
      chk("entryhi_out", entryhi_out, e_ehi);
      chk("entrylo0_out", entrylo0_out, e_elo0);
      chk("entrylo1_out", entrylo1_out, e_elo1);
      chk("index_out", index_out, e_index);
    end
    model_step();
    if (rst) primed = 1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] code, input logic [31:0] hi, input logic [31:0] lo0,
                       input logic [31:0] lo1, input logic [IW-1:0] idx);
    int lat;
    op_code = code; entryhi_in = hi; entrylo0_in = lo0; entrylo1_in = lo1; index_in = idx;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    lat = 1;
    while (!op_done && lat < 8) begin
      step();
      lat++;
    end
    chk("op_latency", lat, 2);
    step();
  endtask

  task automatic look(input logic [31:0] va, input logic [7:0] asid, input logic st);
    lookup_req = 1'b1; lookup_vaddr = va; lookup_asid = asid; lookup_store = st;
    step();
    lookup_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; lookup_req = 1'b0; lookup_vaddr = '0; lookup_store = 1'b0; lookup_asid = '0;
    op_valid = 1'b0; op_code = '0; entryhi_in = '0; entrylo0_in = '0; entrylo1_in = '0;
    index_in = '0; wired_in = 4'd4;
    repeat (3) step();
    chk("rst_random", random_out, 15);
    chk("rst_ack", lookup_ack, 0);
    chk("rst_done", op_done, 0);
    chk("rst_index", index_out, 0);
    rst = 1'b0;

    // Random walks 15..4 then wraps; first lookup (non-zero ASID) misses.
    lookup_req = 1'b1; lookup_vaddr = 32'h0000_1000; lookup_asid = 8'd1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("random_seq", random_out, (k <= 11) ? 15 - k : 15);
      if (k == 1) begin
        chk("first_ack", lookup_ack, 1);
        chk("first_miss", lookup_miss, 1);
        chk("first_paddr", lookup_paddr, 0);
        chk("ready_after_rst", op_ready, 1);
      end
    end
    lookup_req = 1'b0;

    // Odd page: PFN 0x74, C=0, D=0, V=1, G=1 (so stored G = 0 & 1 = 0).
    do_op(2'b01, 32'h0040_2005, 32'h0000_1016, 32'h0000_1D03, 4'd3);
    look(32'h0040_2ABC, 8'd5, 1'b0);
    chk("even_paddr", lookup_paddr, 32'h0004_0ABC);
    chk("even_uncached", lookup_uncached, 1);
    look(32'h0040_3ABC, 8'd5, 1'b1);
    chk("odd_store_mod", lookup_modified, 1);
    chk("odd_store_paddr", lookup_paddr, 0);
    look(32'h0040_3ABC, 8'd5, 1'b0);
    chk("odd_load_paddr", lookup_paddr, 32'h0007_4ABC);
    look(32'h0040_3ABC, 8'd9, 1'b1);
    chk("asid_miss", lookup_miss, 1);

    do_op(2'b11, 32'h0040_2005, 32'h0, 32'h0, 4'd0);
    chk("tlbp_hit", index_out, 32'h0000_0003);
    do_op(2'b11, 32'h0080_0005, 32'h0, 32'h0, 4'd0);
    chk("tlbp_miss", index_out, 32'h8000_0000);
    do_op(2'b00, 32'h0, 32'h0, 32'h0, 4'd3);
    chk("tlbr_hi", entryhi_out, 32'h0040_2005);
    chk("tlbr_lo0", entrylo0_out, 32'h0000_1016);
    chk("tlbr_lo1", entrylo1_out, 32'h0000_1D02);
    chk("tlbp_held", index_out, 32'h8000_0000);

    n = 0;
    while (random_out != 4'd7 && n < 20) begin
      step();
      n++;
    end
    chk("rand_reach_7", random_out, 7);
    do_op(2'b10, 32'h0123_4022, 32'h0000_2006, 32'h0000_2006, 4'd0);
    do_op(2'b11, 32'h0123_4022, 32'h0, 32'h0, 4'd0);
    chk("tlbwr_slot", index_out, 32'h0000_0007);
    do_op(2'b00, 32'h0, 32'h0, 32'h0, 4'd6);
    chk("tlbwr_neighbour", entryhi_out, 32'h0);

    // Reset during EXEC of a TLBWI aborts it.
    op_code = 2'b01; entryhi_in = 32'h0055_6001; entrylo0_in = 32'h0000_1006;
    entrylo1_in = 32'h0000_1006; index_in = 4'd5; op_valid = 1'b1;
    step();
    op_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_done0", op_done, 0);
    step();
    chk("abort_done1", op_done, 0);
    chk("abort_ready", op_ready, 1);
    look(32'h0055_6000, 8'd1, 1'b0);
    chk("abort_miss", lookup_miss, 1);

    // Randomised traffic with a small address/ASID space to force collisions.
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      lookup_req   = ($urandom_range(0, 3) != 0);
      lookup_vaddr = {19'($urandom_range(0, 3)), 13'($urandom)};
      lookup_store = 1'($urandom);
      lookup_asid  = 8'($urandom_range(0, 3));
      op_valid     = ($urandom_range(0, 2) == 0);
      op_code      = 2'($urandom);
      entryhi_in   = {19'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 3))};
      entrylo0_in  = $urandom;
      entrylo1_in  = $urandom;
      index_in     = IW'($urandom);
      if ($urandom_range(0, 199) == 0) wired_in = IW'($urandom);
      step();
    end
    rst = 1'b0; op_valid = 1'b0; lookup_req = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
